// File: rtl/flag_status_unit.sv
// rtl/flag_status_unit.sv - architected N/Z/C/V flags, in-flight flag-write tracking and ID stall.
// Optional feature: FLAG_BYPASS_EN forwards the committing flags straight to the condition evaluator.
module flag_status_unit #(
    parameter int MAX_PENDING = 3,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_Valid,
    input  logic [3:0]        ID_Cond,
    input  logic              ID_S,
    input  logic              ID_Advance,
    input  logic              WB_Flag_We,
    input  logic              WB_N,
    input  logic              WB_Z,
    input  logic              WB_C,
    input  logic              WB_V,
    input  logic              Flush,
    output logic              N,
    output logic              Z,
    output logic              C,
    output logic              V,
    output logic              Cond_N,
    output logic              Cond_Z,
    output logic              Cond_C,
    output logic              Cond_V,
    output logic              Flag_Stall,
    output logic [PEND_W-1:0] Pending,
    output logic              Pend_Err
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [3:0]        flags_q, flags_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              err_q, err_d;

    logic [3:0] wb_flags;
    logic [3:0] cond_flags;
    logic       reads_flags;
    logic       flags_not_ready;
    logic       raw, full, inc, dec;

    assign wb_flags    = {WB_N, WB_Z, WB_C, WB_V};
    // AL (1110) and the 1111 encoding are unconditional
    assign reads_flags = (ID_Cond[3:1] != 3'b111);

`ifdef FLAG_BYPASS_EN
    assign cond_flags      = WB_Flag_We ? wb_flags : flags_q;
    // the last outstanding write is forwarded in its own commit cycle
    assign flags_not_ready = (pend_q > PEND_ONE) | ((pend_q == PEND_ONE) & ~WB_Flag_We);
`else
    assign cond_flags      = flags_q;
    assign flags_not_ready = (pend_q != '0);
`endif

    assign dec        = WB_Flag_We & (pend_q != '0);
    assign raw        = reads_flags & flags_not_ready;
    assign full       = ID_S & (pend_q == PEND_MAX) & ~dec;
    assign Flag_Stall = ID_Valid & (raw | full);
    assign inc        = ID_Valid & ID_S & ID_Advance & ~Flag_Stall & ~Flush;

    always_comb begin
        flags_d = flags_q;
        pend_d  = pend_q;
        err_d   = err_q;
        if (WB_Flag_We) begin
            flags_d = wb_flags;
        end
        // a flush drops every younger in-flight producer, including this cycle's issue
        if (Flush) begin
            pend_d = '0;
        end else if (inc && !dec) begin
            pend_d = pend_q + PEND_ONE;
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_ONE;
        end
        if (WB_Flag_We && (pend_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign {N, Z, C, V}                     = flags_q;
    assign {Cond_N, Cond_Z, Cond_C, Cond_V} = cond_flags;
    assign Pending                          = pend_q;
    assign Pend_Err                         = err_q;

endmodule

// File: tb/tb_flag_status_unit.sv
// tb/tb_flag_status_unit.sv - scoreboard bench for flag_status_unit (default and FLAG_BYPASS_EN builds).
module tb_flag_status_unit;

`ifdef FLAG_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_s, id_adv, wb_we, flush;
    logic [3:0] id_cond, wb;
    logic       n, z, c, v, cn, cz, cc, cv, stall, perr;
    logic [1:0] pend;

    int n_cmp = 0;
    int n_bad = 0;

    // expected vector: {stall, pending[1:0], nzcv[3:0], cond[3:0], err}
    typedef struct packed {
        logic        v;
        logic [3:0]  cond;
        logic        s;
        logic        adv;
        logic        we;
        logic [3:0]  wb;
        logic        fl;
        logic [11:0] e;
    } row_t;

    logic [11:0] sb[$];

    always #5 clk = ~clk;

    flag_status_unit #(.MAX_PENDING(3), .PEND_W(2)) dut (
        .clk(clk), .reset(reset),
        .ID_Valid(id_valid), .ID_Cond(id_cond), .ID_S(id_s), .ID_Advance(id_adv),
        .WB_Flag_We(wb_we), .WB_N(wb[3]), .WB_Z(wb[2]), .WB_C(wb[1]), .WB_V(wb[0]),
        .Flush(flush),
        .N(n), .Z(z), .C(c), .V(v),
        .Cond_N(cn), .Cond_Z(cz), .Cond_C(cc), .Cond_V(cv),
        .Flag_Stall(stall), .Pending(pend), .Pend_Err(perr)
    );

    function automatic logic [11:0] ex(input logic st, input logic [1:0] p, input logic [3:0] f,
                                       input logic [3:0] cd, input logic er);
        return {st, p, f, cd, er};
    endfunction

    function automatic row_t mk(input logic vl, input logic [3:0] cd, input logic s, input logic adv,
                                input logic we, input logic [3:0] w, input logic fl, input logic [11:0] e);
        row_t r;
        r.v = vl; r.cond = cd; r.s = s; r.adv = adv; r.we = we; r.wb = w; r.fl = fl; r.e = e;
        return r;
    endfunction

    task automatic drive(input row_t r);
        id_valid = r.v; id_cond = r.cond; id_s = r.s; id_adv = r.adv;
        wb_we = r.we; wb = r.wb; flush = r.fl;
    endtask

    function automatic logic [11:0] observe();
        return {stall, pend, n, z, c, v, cn, cz, cc, cv, perr};
    endfunction

    task automatic test_reset();
        row_t rows[$];
        logic [11:0] got, want;
        reset = 1'b1;
        drive(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 12'h0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rows.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'h0, 4'h0, 1'b0)));
        rows.push_back(mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'h0, 4'h0, 1'b0)));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset[%0d]: got stall/pend/nzcv/cond/err=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b", i,
                         got[11], got[10:9], got[8:5], got[4:1], got[0], want[11], want[10:9], want[8:5], want[4:1], want[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_raw();
        row_t rows[$];
        logic [11:0] got, want;
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'h0, 4'h0, 1'b0)));
        rows.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b1, 2'd1, 4'h0, 4'h0, 1'b0)));
        rows.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b1, 2'd1, 4'h0, 4'h0, 1'b0)));
        rows.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0,
                          ex(~BYP, 2'd1, 4'h0, BYP ? 4'b0100 : 4'b0000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'b0100, 4'b0100, 1'b0)));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL raw[%0d]: got stall/pend/nzcv/cond/err=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b", i,
                         got[11], got[10:9], got[8:5], got[4:1], got[0], want[11], want[10:9], want[8:5], want[4:1], want[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_always_lt();
        row_t rows[$];
        logic [11:0] got, want;
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'b0100, 4'b0100, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd1, 4'b0100, 4'b0100, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd2, 4'b0100, 4'b0100, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0,
                          ex(1'b1, 2'd2, 4'b0100, BYP ? 4'b0000 : 4'b0100, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0,
                          ex(~BYP, 2'd1, 4'b0000, BYP ? 4'b1000 : 4'b0000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'b1000, 4'b1000, 1'b0)));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL al_lt[%0d]: got stall/pend/nzcv/cond/err=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b", i,
                         got[11], got[10:9], got[8:5], got[4:1], got[0], want[11], want[10:9], want[8:5], want[4:1], want[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full();
        row_t rows[$];
        logic [11:0] got, want;
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'b1000, 4'b1000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd1, 4'b1000, 4'b1000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd2, 4'b1000, 4'b1000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b1, 2'd3, 4'b1000, 4'b1000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ex(1'b1, 2'd3, 4'b1000, 4'b1000, 1'b0)));
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0,
                          ex(1'b0, 2'd3, 4'b1000, BYP ? 4'b0010 : 4'b1000, 1'b0)));
        rows.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd3, 4'b0010, 4'b0010, 1'b0)));
        rows.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0,
                          ex(1'b0, 2'd3, 4'b0010, BYP ? 4'b0000 : 4'b0010, 1'b0)));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL full[%0d]: got stall/pend/nzcv/cond/err=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b", i,
                         got[11], got[10:9], got[8:5], got[4:1], got[0], want[11], want[10:9], want[8:5], want[4:1], want[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        logic [11:0] got, want;
        rows.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1,
                          ex(1'b0, 2'd2, 4'b0000, BYP ? 4'b1000 : 4'b0000, 1'b0)));
        rows.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'b1000, 4'b1000, 1'b0)));
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL flush[%0d]: got stall/pend/nzcv/cond/err=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b", i,
                         got[11], got[10:9], got[8:5], got[4:1], got[0], want[11], want[10:9], want[8:5], want[4:1], want[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_underflow();
        row_t rows[$];
        logic [11:0] got, want;
        rows.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0,
                          ex(1'b0, 2'd0, 4'b1000, BYP ? 4'b0001 : 4'b1000, 1'b0)));
        for (int k = 0; k < 10; k++) begin
            rows.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, ex(1'b0, 2'd0, 4'b0001, 4'b0001, 1'b1)));
        end
        foreach (rows[i]) begin
            drive(rows[i]); sb.push_back(rows[i].e); #1;
            got = observe(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL underflow[%0d]: got stall/pend/nzcv/cond/err=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b", i,
                         got[11], got[10:9], got[8:5], got[4:1], got[0], want[11], want[10:9], want[8:5], want[4:1], want[0]);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(ex(1'b0, 2'd0, 4'h0, 4'h0, 1'b0));
        #1;
        got = observe(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL err_clear: got stall/pend/nzcv/cond/err=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b",
                     got[11], got[10:9], got[8:5], got[4:1], got[0], want[11], want[10:9], want[8:5], want[4:1], want[0]);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 12'h0));
        @(negedge clk);
        test_reset();
        test_raw();
        test_always_lt();
        test_full();
        test_flush();
        test_underflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flag_status_unit.md
Name: flag_status_unit

Overview:
- Holds the architected N/Z/C/V status flags and supplies them to the ID-stage condition evaluator.
- Counts in-flight flag-setting instructions between issue and flag writeback, so variable-latency producers (ALU, multiplier) are tracked.
- Stalls ID when a conditional instruction would otherwise read stale flags.
- Sits between the writeback-side flag producers and the ID-stage condition evaluation / hazard logic.

Parameters:
- MAX_PENDING, 3: maximum number of outstanding flag-setting instructions.
- PEND_W, 2: width of the pending counter; must satisfy 2^PEND_W > MAX_PENDING.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ID_Valid  in  1  ID-stage instruction is valid.
- ID_Cond  in  4  condition code of the ID instruction.
- ID_S  in  1  ID instruction updates flags (S bit).
- ID_Advance  in  1  ID instruction moves to EX this cycle (the hazard unit has already accounted for other stalls).
- WB_Flag_We  in  1  a producer commits new flags this cycle.
- WB_N, WB_Z, WB_C, WB_V  in  1 each  flag values being committed.
- Flush  in  1  pipeline flush; kills all younger in-flight instructions.
- N, Z, C, V  out  1 each  architected flag register.
- Cond_N, Cond_Z, Cond_C, Cond_V  out  1 each  flags presented to the condition evaluator.
- Flag_Stall  out  1  hold the ID instruction this cycle.
- Pending  out  PEND_W  current outstanding flag-write count.
- Pend_Err  out  1  sticky error: underflow, or a write while Pending==0.

Behaviour:
- Reset values: N=Z=C=V=0, Pending=0, Pend_Err=0. Flag_Stall and Cond_* are combinational and follow from these values.
- Flag register: on a rising edge with WB_Flag_We=1, {N,Z,C,V} <= {WB_N,WB_Z,WB_C,WB_V}. Otherwise the register holds.
- Definitions used below:
  - inc = ID_Valid & ID_S & ID_Advance & ~Flag_Stall & ~Flush
  - dec = WB_Flag_We & (Pending != 0)
- Pending update:
  - Pending_next = Pending + inc - dec.
  - When inc and dec are both 1 in the same cycle, Pending is unchanged.
- Underflow: WB_Flag_We=1 while Pending==0 still commits the flags, leaves Pending at 0, and sets Pend_Err. Pend_Err stays set until reset.
- Flag-reading instructions:
  - ID_Cond values 4'b1110 (AL) and 4'b1111 need no flags.
  - All other codes read flags.
- Flag_Stall = ID_Valid & (RAW | FULL), where:
  - RAW = the ID instruction reads flags & flags_not_ready
  - FULL = ID_S & (Pending == MAX_PENDING) & ~dec
- flags_not_ready depends on the optional feature (see below).
- Flush:
  - Pending <= 0 on the next edge; inc is suppressed in the Flush cycle.
  - A WB_Flag_We arriving in the same cycle still commits its flags, because that producer is older than the flush point.
  - Pending still clears to 0; no Pend_Err is raised.
- reset has priority over Flush and over writes.
- Latency: a flag commit is visible on N/Z/C/V one cycle after WB_Flag_We.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined (bypass on):
  - Cond_* = WB_* when WB_Flag_We=1, otherwise equal to N/Z/C/V.
  - flags_not_ready = (Pending > 1) | (Pending == 1 & ~WB_Flag_We).
  - A conditional instruction sees the last outstanding write in the same cycle that write commits.
- Undefined (bypass off):
  - Cond_* = N/Z/C/V always.
  - flags_not_ready = (Pending != 0).
  - A conditional instruction waits one extra cycle after the final commit.

Test Plan:
- Reset held 2 cycles with WB_Flag_We=1, WB_*=1 -> NZCV=0000, Pending=0, Pend_Err=0, Flag_Stall=0 after release.
- Issue one ID_S instruction (ID_Advance=1), then next cycle ID_Cond=0000 (EQ) with no writeback -> Pending=1, Flag_Stall=1. Two cycles later, WB_Flag_We=1 with WB_Z=1:
  - With FLAG_BYPASS_EN: Flag_Stall=0 and Cond_Z=1 in that same cycle.
  - Without it: stall persists one more cycle, then Cond_Z=1 from Z.
- ID_Cond=1110 while Pending=2 -> Flag_Stall=0. Then ID_Cond=1011 (LT) -> Flag_Stall=1 until Pending drops to 0 (or to 1 with a coinciding commit, under bypass).
- Issue 3 ID_S instructions with no writeback -> Pending=3. A 4th ID_S -> Flag_Stall=1. The 4th proceeds in the cycle WB_Flag_We=1 arrives, and Pending stays at 3.
- Pending=2, Flush=1 together with WB_Flag_We=1, WB_N=1 and an advancing ID_S instruction -> next cycle Pending=0, N=1, Pend_Err=0, no increment.
- WB_Flag_We=1 with Pending=0 -> flags committed, Pending=0, Pend_Err=1 and still 1 after 10 idle cycles; cleared only by reset.
